// File: rtl/wave_pwm_dac.sv
// wave_pwm_dac
//   1-bit PWM DAC for waveform samples. A one-entry holding buffer takes
//   samples over a valid/ready handshake. The buffered sample becomes the
//   duty value only on a PWM period boundary, so the output never glitches
//   mid-period. Every boundary that finds no sample is counted as an underrun.
//
// Parameters
//   DW        sample width; a PWM period is 2^DW-1 ticks
//   PRESCALE  clocks per PWM tick (>= 1)
//   UCNT_W    width of the saturating underrun counter
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active-high
//   enable          run the PWM; low holds the counters at zero and drives pwm_o low
//   sample_i        next duty value (unsigned)
//   sample_vld_i    sample_i is valid
//   sample_rdy_o    buffer can accept a sample (low while rst is high)
//   pwm_o           registered PWM output
//   period_start_o  pulse on the first cycle of each PWM period
//   underrun_o      pulse after a boundary that found no sample
//   underrun_cnt_o  saturating underrun count
module wave_pwm_dac #(
    parameter int DW       = 8,
    parameter int PRESCALE = 1,
    parameter int UCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DW-1:0]     sample_i,
    input  logic              sample_vld_i,
    output logic              sample_rdy_o,
    output logic              pwm_o,
    output logic              period_start_o,
    output logic              underrun_o,
    output logic [UCNT_W-1:0] underrun_cnt_o
);

    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    // Last count of a period: 2^DW-2, so the period is 2^DW-1 ticks and a
    // duty of all-ones keeps the output high for the whole period.
    localparam logic [DW-1:0] CNT_MAX    = {{(DW-1){1'b1}}, 1'b0};

    function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [PW-1:0] presc;
    logic [DW-1:0] cnt;
    logic [DW-1:0] duty;
    logic [DW-1:0] sample_buf;
    logic          buf_full;
    logic          enable_p1;

    logic tick;
    logic boundary;
    logic accept;
    logic underrun_now;

    assign sample_rdy_o = ~rst & ~buf_full;
    assign accept       = sample_vld_i & sample_rdy_o;
    assign tick         = enable && (presc == PRESC_LAST);
    assign boundary     = tick && (cnt == CNT_MAX);
    // A sample arriving on the boundary cycle itself is bypassed into duty,
    // so that case does not count as an underrun.
    assign underrun_now = boundary && !buf_full && !accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc          <= '0;
            cnt            <= '0;
            duty           <= '0;
            sample_buf     <= '0;
            buf_full       <= 1'b0;
            enable_p1      <= 1'b0;
            pwm_o          <= 1'b0;
            period_start_o <= 1'b0;
            underrun_o     <= 1'b0;
            underrun_cnt_o <= '0;
        end else begin
            if (!enable) begin
                presc <= '0;
                cnt   <= '0;
            end else if (tick) begin
                presc <= '0;
                cnt   <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end

            // Output stage: compare of the current count/duty, one clock late
            pwm_o          <= enable && (cnt < duty);
            period_start_o <= boundary || (enable && !enable_p1);
            enable_p1      <= enable;
            underrun_o     <= underrun_now;
            if (underrun_now) begin
                underrun_cnt_o <= sat_inc(underrun_cnt_o);
            end

            // A full buffer holds ready low, so it can never accept on the
            // cycle its contents move into duty.
            if (boundary && buf_full) begin
                duty     <= sample_buf;
                buf_full <= 1'b0;
            end else if (boundary && accept) begin
                duty <= sample_i;
            end else if (accept) begin
                sample_buf <= sample_i;
                buf_full   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wave_pwm_dac.sv
// Bench for wave_pwm_dac: instance 0 uses PRESCALE=1 / 16-bit counter,
// instance 1 uses PRESCALE=4 / 3-bit counter so saturation is reachable.
// A reference model tracks elapsed enabled clocks and a one-slot sample
// buffer; every output is compared each cycle, and per-period high counts
// are measured from the outputs for the directed scenarios.
module tb_wave_pwm_dac;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       vld [2];
    logic [7:0] smp [2];
    logic       rdy [2];
    logic       pwm [2];
    logic       ps  [2];
    logic       ur  [2];
    logic [15:0] ucnt_a;
    logic [2:0]  ucnt_b;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int per_m  [2] = '{1, 4};
    int umax_m [2] = '{65535, 7};
    int e_m    [2];
    int duty_m [2];
    int bufv_m [2];
    int ucnt_m [2];
    bit buff_m [2];
    bit enp_m  [2];
    bit xpwm   [2];
    bit xps    [2];
    bit xur    [2];

    // measurements taken from the DUT outputs
    int hi_acc   [2];
    int len_acc  [2];
    int last_hi  [2];
    int last_len [2];
    int ps_count [2];

    always #5 clk = ~clk;

    wave_pwm_dac #(.DW(8), .PRESCALE(1), .UCNT_W(16)) u_dac0 (
        .clk(clk), .rst(rst), .enable(enable),
        .sample_i(smp[0]), .sample_vld_i(vld[0]), .sample_rdy_o(rdy[0]),
        .pwm_o(pwm[0]), .period_start_o(ps[0]), .underrun_o(ur[0]),
        .underrun_cnt_o(ucnt_a)
    );

    wave_pwm_dac #(.DW(8), .PRESCALE(4), .UCNT_W(3)) u_dac1 (
        .clk(clk), .rst(rst), .enable(enable),
        .sample_i(smp[1]), .sample_vld_i(vld[1]), .sample_rdy_o(rdy[1]),
        .pwm_o(pwm[1]), .period_start_o(ps[1]), .underrun_o(ur[1]),
        .underrun_cnt_o(ucnt_b)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int ucnt_obs(input int k);
        return (k == 0) ? int'(ucnt_a) : int'(ucnt_b);
    endfunction

    // Advance the model across one rising edge using the inputs seen there.
    task automatic model_step(input int k);
        int period;
        bit hs;
        bit bnd;
        if (rst) begin
            e_m[k] = 0; duty_m[k] = 0; buff_m[k] = 0; ucnt_m[k] = 0;
            enp_m[k] = 0; xpwm[k] = 0; xps[k] = 0; xur[k] = 0;
            return;
        end
        period = 255 * per_m[k];
        hs  = vld[k] && !buff_m[k];
        bnd = enable && (e_m[k] == period - 1);
        xpwm[k] = enable && ((e_m[k] / per_m[k]) < duty_m[k]);
        xps[k]  = bnd || (enable && !enp_m[k]);
        xur[k]  = bnd && !buff_m[k] && !hs;
        if (xur[k] && ucnt_m[k] < umax_m[k]) ucnt_m[k]++;
        if (bnd && buff_m[k]) begin
            duty_m[k] = bufv_m[k];
            buff_m[k] = 1'b0;
        end else if (bnd && hs) begin
            duty_m[k] = int'(smp[k]);
        end else if (hs) begin
            bufv_m[k] = int'(smp[k]);
            buff_m[k] = 1'b1;
        end
        e_m[k]   = enable ? (e_m[k] + 1) % period : 0;
        enp_m[k] = enable;
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("pwm%0d", k),  int'(pwm[k]), int'(xpwm[k]));
            check_eq($sformatf("pstart%0d", k), int'(ps[k]), int'(xps[k]));
            check_eq($sformatf("underrun%0d", k), int'(ur[k]), int'(xur[k]));
            check_eq($sformatf("ucnt%0d", k), ucnt_obs(k), ucnt_m[k]);
            check_eq($sformatf("rdy%0d", k), int'(rdy[k]), int'(!rst && !buff_m[k]));
            if (rst) begin
                hi_acc[k] = 0; len_acc[k] = 0;
            end else begin
                hi_acc[k]  += int'(pwm[k]);
                len_acc[k] += 1;
                if (ps[k]) begin
                    last_hi[k]  = hi_acc[k];
                    last_len[k] = len_acc[k];
                    hi_acc[k]   = 0;
                    len_acc[k]  = 0;
                    ps_count[k]++;
                end
            end
        end
    end

    // Offer a sample to instance k and hold it until it is taken.
    task automatic push(input int k, input int v);
        int n = 0;
        @(negedge clk);
        smp[k] = 8'(v);
        vld[k] = 1'b1;
        while (!rdy[k] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        vld[k] = 1'b0;
        check_eq($sformatf("push_accept%0d", k), int'(n < 5000), 1);
    endtask

    task automatic wait_ps(input int k, input int n);
        int tgt = ps_count[k] + n;
        int t = 0;
        while (ps_count[k] < tgt && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check_eq($sformatf("period_seen%0d", k), int'(ps_count[k] >= tgt), 1);
    endtask

    initial begin
        int saved;
        int t;
        vld[0] = 1'b0; vld[1] = 1'b0;
        smp[0] = 8'h00; smp[1] = 8'h00;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        enable = 1'b1;

        fork
            begin
                // idle source: output low, underrun every period
                wait_ps(0, 3);
                check_eq("t1_ucnt", int'(ucnt_a), 2);
                check_eq("t1_period_len", last_len[0], 255);
                check_eq("t1_high", last_hi[0], 0);

                push(0, 8'h80);
                wait_ps(0, 2);
                check_eq("t2_high", last_hi[0], 128);
                check_eq("t2_period_len", last_len[0], 255);

                saved = int'(ucnt_a);
                push(0, 8'hFF);
                push(0, 8'h00);
                wait_ps(0, 1);
                check_eq("t3_full_high", last_hi[0], 255);
                push(0, 8'h00);
                wait_ps(0, 1);
                check_eq("t3_zero_high", last_hi[0], 0);
                check_eq("t3_no_underrun", int'(ucnt_a), saved);

                push(0, 8'h20);
                push(0, 8'hC0);
                wait_ps(0, 1);
                check_eq("t4_high_20", last_hi[0], 32);
                wait_ps(0, 1);
                check_eq("t4_high_c0", last_hi[0], 192);

                // sample offered exactly on the boundary cycle
                t = 0;
                while (!(e_m[0] == 254 && !buff_m[0]) && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                smp[0] = 8'h40;
                vld[0] = 1'b1;
                @(negedge clk);
                vld[0] = 1'b0;
                check_eq("t5_pstart", int'(ps[0]), 1);
                check_eq("t5_no_underrun", int'(ur[0]), 0);
                wait_ps(0, 1);
                check_eq("t5_high", last_hi[0], 64);

                for (int i = 0; i < 4000; i++) begin
                    @(negedge clk);
                    vld[0] = ($urandom_range(0, 9) == 0);
                    smp[0] = 8'($urandom);
                    if (i == 2000) enable = 1'b0;
                    if (i == 2050) enable = 1'b1;
                end
                @(negedge clk);
                vld[0] = 1'b0;
            end
            begin
                push(1, 8'h80);
                wait_ps(1, 2);
                check_eq("t6_high", last_hi[1], 512);
                check_eq("t6_period_len", last_len[1], 1020);
                wait_ps(1, 9);
                check_eq("ucnt_saturated", int'(ucnt_b), 7);
            end
        join

        // reset in the middle of a high phase
        t = 0;
        while (!pwm[1] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_eq("t6_found_high", int'(pwm[1]), 1);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_pwm", int'(pwm[1]), 0);
        check_eq("t6_rst_rdy", int'(rdy[1]), 0);
        check_eq("t6_rst_ucnt", int'(ucnt_b), 0);
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_rdy", int'(rdy[1]), 1);
        enable = 1'b1;
        push(1, 8'h10);
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
